// File: rtl/ledg_pwm_pkg.sv
// Shared constants for the green-LED PWM driver: register addresses and CTRL bit positions.
package ledg_pwm_pkg;

  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_DUTY     = 2'd1;
  localparam logic [1:0] ADDR_PRESCALE = 2'd2;
  localparam logic [1:0] ADDR_BLINK    = 2'd3;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_BLINK  = 1;

  localparam int BLINK_W = 16;

endpackage

// File: rtl/ledg_pwm_if.sv
// Avalon-MM slave bus bundle for the LED PWM driver register file.
interface ledg_pwm_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, output chipselect, output write_n, output writedata,
                  input readdata);
  modport slave  (input address, input chipselect, input write_n, input writedata,
                  output readdata);

endinterface

// File: rtl/ledg_pwm_timebase.sv
// Tick prescaler and PWM frame counter; a PRESCALE write restarts the prescaler at 0.
module ledg_pwm_timebase #(
  parameter int PWM_BITS   = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  prescale_wr,
  output logic [PWM_BITS-1:0]   pwm_cnt_r,
  output logic                  frame_end_s
);

  logic [PRESCALE_W-1:0] pre_cnt_r;
  logic                  tick_s;

  assign tick_s      = (pre_cnt_r == prescale);
  assign frame_end_s = tick_s && (pwm_cnt_r == {PWM_BITS{1'b1}});

  // Prescaler wrap and PWM counter advance
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt_r <= '0;
      pwm_cnt_r <= '0;
    end else begin
      if (prescale_wr) begin
        pre_cnt_r <= '0;
      end else if (tick_s) begin
        pre_cnt_r <= '0;
      end else begin
        pre_cnt_r <= pre_cnt_r + 1'b1;
      end
      if (tick_s) begin
        pwm_cnt_r <= pwm_cnt_r + 1'b1;
      end else begin
        pwm_cnt_r <= pwm_cnt_r;
      end
    end
  end

endmodule

// File: rtl/ledg_pwm_driver.sv
// Green-LED PWM/blink driver behind the LEDG PIO. Optional gamma-corrected duty:
// define LEDG_PWM_GAMMA_EN.
module ledg_pwm_driver
  import ledg_pwm_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PWM_BITS   = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  ledg_pwm_if.slave        bus,
  input  logic [WIDTH-1:0] pattern_in,
  output logic [WIDTH-1:0] led_out
);

  logic [1:0]            ctrl_r;
  logic [PWM_BITS-1:0]   duty_r;
  logic [PRESCALE_W-1:0] prescale_r;
  logic [BLINK_W-1:0]    blink_r;
  logic [WIDTH-1:0]      pat_q_r;
  logic [PWM_BITS-1:0]   duty_q_r;
  logic [BLINK_W-1:0]    blink_cnt_r;
  logic                  blink_phase_r;
  logic [WIDTH-1:0]      led_out_r;
  logic [PWM_BITS-1:0]   pwm_cnt_s;
  logic                  frame_end_s;
  logic                  wr_s;
  logic                  prescale_wr_s;
  logic                  blink_active_s;
  logic                  pwm_on_s;
  logic [PWM_BITS-1:0]   duty_load_s;

  assign wr_s           = bus.chipselect && !bus.write_n;
  assign prescale_wr_s  = wr_s && (bus.address == ADDR_PRESCALE);
  assign blink_active_s = ctrl_r[CTRL_BLINK] && (blink_r != '0);
  assign led_out        = led_out_r;

`ifdef LEDG_PWM_GAMMA_EN
  function automatic logic [PWM_BITS-1:0] gamma_f(input logic [PWM_BITS-1:0] d);
    logic [2*PWM_BITS-1:0] sq;
    sq = d * d;
    if (d == {PWM_BITS{1'b1}}) begin
      gamma_f = {PWM_BITS{1'b1}};
    end else begin
      gamma_f = sq[2*PWM_BITS-1:PWM_BITS];
    end
  endfunction
  assign duty_load_s = gamma_f(duty_r);
`else
  assign duty_load_s = duty_r;
`endif

  ledg_pwm_timebase #(.PWM_BITS(PWM_BITS), .PRESCALE_W(PRESCALE_W)) u_timebase (
    .clk         (clk),
    .reset_n     (reset_n),
    .prescale    (prescale_r),
    .prescale_wr (prescale_wr_s),
    .pwm_cnt_r   (pwm_cnt_s),
    .frame_end_s (frame_end_s)
  );

  // Full-scale duty is a special case so the LEDs reach 100% rather than 255/256
  always_comb begin
    if (duty_q_r == {PWM_BITS{1'b1}}) begin
      pwm_on_s = 1'b1;
    end else begin
      pwm_on_s = (pwm_cnt_s < duty_q_r);
    end
  end

  // Zero-wait-state register readback, unused bits read as zero
  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_CTRL:     bus.readdata[1:0]            = ctrl_r;
      ADDR_DUTY:     bus.readdata[PWM_BITS-1:0]   = duty_r;
      ADDR_PRESCALE: bus.readdata[PRESCALE_W-1:0] = prescale_r;
      ADDR_BLINK:    bus.readdata[BLINK_W-1:0]    = blink_r;
      default:       bus.readdata                 = '0;
    endcase
  end

  // Software-visible register file
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_r     <= '0;
      duty_r     <= '0;
      prescale_r <= '0;
      blink_r    <= '0;
    end else if (wr_s) begin
      case (bus.address)
        ADDR_CTRL:     ctrl_r     <= bus.writedata[1:0];
        ADDR_DUTY:     duty_r     <= bus.writedata[PWM_BITS-1:0];
        ADDR_PRESCALE: prescale_r <= bus.writedata[PRESCALE_W-1:0];
        ADDR_BLINK:    blink_r    <= bus.writedata[BLINK_W-1:0];
        default:       ctrl_r     <= ctrl_r;
      endcase
    end
  end

  // Frame-boundary shadows and blink phase; writes landing on frame_end show up one frame later
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pat_q_r       <= '0;
      duty_q_r      <= '0;
      blink_cnt_r   <= '0;
      blink_phase_r <= 1'b1;
    end else begin
      if (frame_end_s) begin
        pat_q_r  <= pattern_in;
        duty_q_r <= duty_load_s;
      end
      if (!blink_active_s) begin
        blink_cnt_r   <= '0;
        blink_phase_r <= 1'b1;
      end else if (frame_end_s) begin
        if (blink_cnt_r == blink_r - 1'b1) begin
          blink_cnt_r   <= '0;
          blink_phase_r <= !blink_phase_r;
        end else begin
          blink_cnt_r <= blink_cnt_r + 1'b1;
        end
      end
    end
  end

  // Registered pin drive
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_out_r <= '0;
    end else if (ctrl_r[CTRL_ENABLE]) begin
      led_out_r <= pat_q_r & {WIDTH{pwm_on_s && blink_phase_r}};
    end else begin
      led_out_r <= '0;
    end
  end

endmodule

// File: tb/tb_ledg_pwm_driver.sv
// Self-checking bench for ledg_pwm_driver: register table, directed PWM/blink/reset sequences,
// and randomized traffic against a frame-level reference model.
module tb_ledg_pwm_driver;
  import ledg_pwm_pkg::*;

  logic       clk;
  logic       reset_n;
  logic [7:0] pattern_in;
  logic [7:0] led_out;

  ledg_pwm_if bus();

  ledg_pwm_driver #(.WIDTH(8), .PWM_BITS(8), .PRESCALE_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .pattern_in (pattern_in),
    .led_out    (led_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state (plain integers)
  int m_ctrl, m_duty, m_pre, m_blink;
  int m_pcnt, m_pwm, m_pat, m_dq, m_bcnt, m_led;
  bit m_phase;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rexp;
  } reg_vec_t;

  reg_vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic int gamma_ref(input int d);
`ifdef LEDG_PWM_GAMMA_EN
    return (d == 255) ? 255 : (d * d) / 256;
`else
    return d;
`endif
  endfunction

  task automatic model_reset();
    m_ctrl = 0; m_duty = 0; m_pre = 0; m_blink = 0;
    m_pcnt = 0; m_pwm = 0; m_pat = 0; m_dq = 0; m_bcnt = 0; m_led = 0;
    m_phase = 1'b1;
  endtask

  task automatic model_step();
    bit tick, fe, on, wr, blink_on;
    tick = (m_pcnt == m_pre);
    fe   = tick && (m_pwm == 255);
    on   = (m_dq == 255) || (m_pwm < m_dq);
    wr   = bus.chipselect && !bus.write_n;
    blink_on = ((m_ctrl & 2) != 0) && (m_blink != 0);
    m_led = ((m_ctrl & 1) != 0 && on && m_phase) ? m_pat : 0;
    if (wr && bus.address == ADDR_PRESCALE) m_pcnt = 0;
    else m_pcnt = tick ? 0 : m_pcnt + 1;
    if (tick) m_pwm = (m_pwm + 1) % 256;
    if (!blink_on) begin
      m_bcnt = 0; m_phase = 1'b1;
    end else if (fe) begin
      if (m_bcnt == m_blink - 1) begin m_bcnt = 0; m_phase = !m_phase; end
      else m_bcnt = (m_bcnt + 1) % 65536;
    end
    if (fe) begin m_pat = pattern_in; m_dq = gamma_ref(m_duty); end
    if (wr) begin
      case (bus.address)
        ADDR_CTRL:     m_ctrl  = bus.writedata & 32'h3;
        ADDR_DUTY:     m_duty  = bus.writedata & 32'hFF;
        ADDR_PRESCALE: m_pre   = bus.writedata & 32'hFFFF;
        default:       m_blink = bus.writedata & 32'hFFFF;
      endcase
    end
  endtask

  // one clock: advance model at the edge, compare 1 time unit later
  task automatic cyc();
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_step();
    #1;
    check("led_out", {24'd0, led_out}, m_led[31:0]);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    cyc();
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    bus.address = a;
    #1;
    check(name, bus.readdata, exp);
  endtask

  task automatic count_on(input int n, input logic [7:0] val, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (led_out == val) c++;
    end
  endtask

  initial begin
    int c;
    int gexp;
    logic [1:0] ra;
    logic [31:0] rd;

    vecs[0] = '{ADDR_CTRL,     32'hFFFF_FFFF, 32'h0000_0003};
    vecs[1] = '{ADDR_DUTY,     32'h0000_1234, 32'h0000_0034};
    vecs[2] = '{ADDR_PRESCALE, 32'h000A_BCDE, 32'h0000_BCDE};
    vecs[3] = '{ADDR_BLINK,    32'h0001_2345, 32'h0000_2345};
    vecs[4] = '{ADDR_CTRL,     32'h0000_0000, 32'h0000_0000};
    vecs[5] = '{ADDR_DUTY,     32'h0000_0000, 32'h0000_0000};
    vecs[6] = '{ADDR_PRESCALE, 32'h0000_0000, 32'h0000_0000};
    vecs[7] = '{ADDR_BLINK,    32'h0000_0000, 32'h0000_0000};

    reset_n = 1'b0; pattern_in = 8'h00;
    bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'd0;
    model_reset();
    run(3);
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) rd_check("reset_reg", a[1:0], 32'd0);
    run(2);

    // register table
    for (int i = 0; i < 8; i++) begin
      wr(vecs[i].addr, vecs[i].wdata);
      rd_check("reg_readback", vecs[i].addr, vecs[i].rexp);
    end

    // full duty, steady pattern
    pattern_in = 8'hA5;
    wr(ADDR_CTRL, 32'd1);
    wr(ADDR_DUTY, 32'hFF);
    run(600);
    check("full_duty_led", {24'd0, led_out}, 32'hA5);
    rd_check("ctrl_read", ADDR_CTRL, 32'h1);

    // quarter duty
    wr(ADDR_DUTY, 32'h40);
    pattern_in = 8'hFF;
    run(600);
    count_on(256, 8'hFF, c);
    check("duty40_on_cycles", c, 32'd64);

    // mid-frame pattern change
    pattern_in = 8'h0F;
    run(600);
    run(100);
    pattern_in = 8'hF0;
    run(600);
    count_on(256, 8'hF0, c);
    check("pattern_switch_on", c, 32'd64);

    // blinking, 2-frame half period
    wr(ADDR_DUTY, 32'hFF);
    wr(ADDR_BLINK, 32'd2);
    wr(ADDR_CTRL, 32'd3);
    run(600);
    count_on(2048, 8'hF0, c);
    check("blink_on_cycles", c, 32'd1024);
    wr(ADDR_BLINK, 32'd0);
    run(5);
    check("blink_off_steady", {24'd0, led_out}, 32'hF0);

    // prescaler = 3, plus restarts mid-count
    wr(ADDR_CTRL, 32'd1);
    wr(ADDR_DUTY, 32'h40);
    wr(ADDR_PRESCALE, 32'd3);
    run(2);
    wr(ADDR_PRESCALE, 32'd3);
    run(1);
    wr(ADDR_PRESCALE, 32'd3);
    run(2100);
    count_on(1024, 8'hF0, c);
    check("prescale3_on_cycles", c, 32'd256);

    // gamma path (raw duty without the macro)
    wr(ADDR_DUTY, 32'h80);
    run(2100);
`ifdef LEDG_PWM_GAMMA_EN
    gexp = 256;
`else
    gexp = 512;
`endif
    count_on(1024, 8'hF0, c);
    check("duty80_on_cycles", c, gexp);
    rd_check("duty_raw_read", ADDR_DUTY, 32'h80);

    // asynchronous reset mid-frame
    wr(ADDR_PRESCALE, 32'd0);
    wr(ADDR_DUTY, 32'hFF);
    pattern_in = 8'hFF;
    run(600);
    run(37);
    check("pre_reset_on", {24'd0, led_out}, 32'hFF);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_led", {24'd0, led_out}, 32'h0);
    model_reset();
    run(2);
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) rd_check("post_reset_reg", a[1:0], 32'd0);
    run(3);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        ra = 2'($urandom_range(0, 3));
        if (ra == ADDR_PRESCALE || ra == ADDR_BLINK) rd = $urandom_range(0, 3);
        else rd = $urandom;
        bus.address = ra; bus.writedata = rd; bus.chipselect = 1'b1; bus.write_n = 1'b0;
      end
      if ($urandom_range(0, 31) == 0) pattern_in = 8'($urandom);
      cyc();
      bus.chipselect = 1'b0; bus.write_n = 1'b1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
